xf100_itcm: RTL and testbench

- Instruction tightly-coupled memory: the responder end of the instruction-fetch interface driven by `xf100_ifu`.
- Accepts fetch requests (PC) over a valid/ready channel and returns the instruction word with its PC over a valid/ready response channel, strictly in order.
- Holds a synchronous-read, word-organised array plus a one-entry skid buffer, giving full throughput with no combinational path from `rsp_ready` to `req_ready`.
- A byte-enabled load port fills the array from the boot loader or debug.

---
 rtl/xf100_itcm.sv | 141 ++++++++++++++
 tb/tb_xf100_itcm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xf100_itcm.sv
// xf100_itcm: instruction TCM answering xf100_ifu fetches, one-entry skid, byte-enabled load port.
// Ports: clk/rst (sync, active-high); ifu_i_req_*/ifu_o_req_ready fetch request;
//        itcm_o_rsp_*/itcm_i_rsp_ready response; ld_i_wr_* loader write.
// Option: define XF100_ITCM_ERR_CHK_EN to flag misaligned or out-of-range fetches.
module xf100_itcm #(
    parameter int DEPTH_LOG2 = 12,
    parameter int PC_W       = 32,
    parameter int INSTR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_i_req_valid,
    input  logic [PC_W-1:0]       ifu_i_req_pc,
    output logic                  ifu_o_req_ready,
    output logic                  itcm_o_rsp_valid,
    output logic [INSTR_W-1:0]    itcm_o_rsp_instr,
    output logic [PC_W-1:0]       itcm_o_rsp_pc,
    output logic                  itcm_o_rsp_err,
    input  logic                  itcm_i_rsp_ready,
    input  logic                  ld_i_wr_en,
    input  logic [DEPTH_LOG2-1:0] ld_i_wr_addr,
    input  logic [31:0]           ld_i_wr_data,
    input  logic [3:0]            ld_i_wr_be
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

    logic [31:0] mem [DEPTH];

    logic               s1_valid_q, s1_valid_d;
    logic [PC_W-1:0]    s1_pc_q, s1_pc_d;
    logic               s1_err_q, s1_err_d;
    logic [INSTR_W-1:0] rdata_q, rdata_d;
    logic               sk_valid_q, sk_valid_d;
    logic [INSTR_W-1:0] sk_instr_q, sk_instr_d;
    logic [PC_W-1:0]    sk_pc_q, sk_pc_d;
    logic               sk_err_q, sk_err_d;

    logic                  accept;
    logic                  s1_out;
    logic                  sk_fill;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] idx;

    assign idx = ifu_i_req_pc[DEPTH_LOG2+1:2];

`ifdef XF100_ITCM_ERR_CHK_EN
    assign req_err = (|ifu_i_req_pc[1:0]) ||
                     (|ifu_i_req_pc[PC_W-1:DEPTH_LOG2+2]);
`else
    // Alias modulo the array size; the dropped PC bits are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{ifu_i_req_pc[1:0],
                              ifu_i_req_pc[PC_W-1:DEPTH_LOG2+2]};
    assign req_err = 1'b0;
`endif

    // Ready depends only on local state and the load strobe, never on rsp_ready.
    assign ifu_o_req_ready  = !ld_i_wr_en && !sk_valid_q;
    assign accept           = ifu_i_req_valid && ifu_o_req_ready;
    assign itcm_o_rsp_valid = sk_valid_q || s1_valid_q;
    assign itcm_o_rsp_instr = sk_valid_q ? sk_instr_q : rdata_q;
    assign itcm_o_rsp_pc    = sk_valid_q ? sk_pc_q : s1_pc_q;
`ifdef XF100_ITCM_ERR_CHK_EN
    assign itcm_o_rsp_err   = sk_valid_q ? sk_err_q : s1_err_q;
`else
    logic unused_err;
    assign unused_err     = sk_err_q ^ s1_err_q;
    assign itcm_o_rsp_err = 1'b0;
`endif

    // S1 leaves directly to the output only when the skid is empty.
    assign s1_out  = s1_valid_q && !sk_valid_q && itcm_i_rsp_ready;
    // A new read would overwrite a stalled S1, so park S1 in the skid.
    assign sk_fill = accept && s1_valid_q && !s1_out;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pc_d    = s1_pc_q;
        s1_err_d   = s1_err_q;
        rdata_d    = rdata_q;
        sk_valid_d = sk_valid_q;
        sk_instr_d = sk_instr_q;
        sk_pc_d    = sk_pc_q;
        sk_err_d   = sk_err_q;

        if (sk_valid_q && itcm_i_rsp_ready) begin
            sk_valid_d = 1'b0;
        end
        if (sk_fill) begin
            sk_valid_d = 1'b1;
            sk_instr_d = rdata_q;
            sk_pc_d    = s1_pc_q;
            sk_err_d   = s1_err_q;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_pc_d    = ifu_i_req_pc;
            s1_err_d   = req_err;
            rdata_d    = req_err ? NOP : INSTR_W'(mem[idx]);
        end else if (s1_out) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_err_q   <= 1'b0;
            rdata_q    <= '0;
            sk_valid_q <= 1'b0;
            sk_instr_q <= '0;
            sk_pc_q    <= '0;
            sk_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            s1_err_q   <= s1_err_d;
            rdata_q    <= rdata_d;
            sk_valid_q <= sk_valid_d;
            sk_instr_q <= sk_instr_d;
            sk_pc_q    <= sk_pc_d;
            sk_err_q   <= sk_err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_i_wr_be[b]) begin
                    mem[ld_i_wr_addr][8*b +: 8] <= ld_i_wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_xf100_itcm.sv
// tb_xf100_itcm: table-driven fetches with a response scoreboard,
// plus hand sequences for stall/skid, byte writes, errors and reset.
module tb_xf100_itcm;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_err;
    logic        rsp_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    xf100_itcm dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_i_req_valid  (req_valid),
        .ifu_i_req_pc     (req_pc),
        .ifu_o_req_ready  (req_ready),
        .itcm_o_rsp_valid (rsp_valid),
        .itcm_o_rsp_instr (rsp_instr),
        .itcm_o_rsp_pc    (rsp_pc),
        .itcm_o_rsp_err   (rsp_err),
        .itcm_i_rsp_ready (rsp_ready),
        .ld_i_wr_en       (wr_en),
        .ld_i_wr_addr     (wr_addr),
        .ld_i_wr_data     (wr_data),
        .ld_i_wr_be       (wr_be)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   nrsp = 0;
    bit   chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response side of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_rsp: got pc %h want none", rsp_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                nrsp++;
                chk("rsp_pc", rsp_pc, e.pc);
                chk("rsp_instr", rsp_instr, e.instr);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                if (chk_lat) chk("latency", cyc - e.cyc, 1);
            end
        end
    end

    // Entered and left at posedge+1; pushes the expectation on accept.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins,
                         input logic err);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_pc    = pc;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_t e;
                e.pc = pc; e.instr = ins; e.err = err; e.cyc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL fetch_timeout: got no accept want accept pc %h", pc);
        end
    endtask

    logic [31:0] model [4096];

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        chk("ready_in_write", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        for (int b = 0; b < 4; b++)
            if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t tbl[4];
    int   base;
    logic [31:0] hold_instr;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        tbl[0] = '{32'h0,  32'h1111_1111, 1'b0};
        tbl[1] = '{32'h4,  32'h2222_2222, 1'b0};
        tbl[2] = '{32'h8,  32'h3333_3333, 1'b0};
        tbl[3] = '{32'hC,  32'h4444_4444, 1'b0};

        idle(2);
        @(negedge clk);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_instr", rsp_instr, 32'd0);
        chk("rst_pc", rsp_pc, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load and back-to-back fetch with a latency check.
        for (int i = 0; i < 4; i++) wr(12'(i), tbl[i].instr, 4'hF);
        chk_lat = 1'b1;
        base = nrsp;
        for (int i = 0; i < 4; i++) fetch(tbl[i].pc, tbl[i].instr, tbl[i].err);
        req_valid = 1'b0;
        idle(3);
        chk_lat = 1'b0;
        chk("b2b_count", nrsp - base, 4);

        // Stall with two outstanding: skid full, output held.
        rsp_ready = 1'b0;
        fetch(32'h0, 32'h1111_1111, 1'b0);
        fetch(32'h4, 32'h2222_2222, 1'b0);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_pc", rsp_pc, 32'h0);
            chk("stall_instr", rsp_instr, 32'h1111_1111);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rel_pc0", rsp_pc, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_valid1", {31'b0, rsp_valid}, 32'd1);
        chk("rel_pc4", rsp_pc, 32'h4);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_empty", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Partial write, colliding request is held off.
        wr(12'd5, 32'hAAAA_AAAA, 4'hF);
        req_valid = 1'b1;
        req_pc    = 32'd20;
        wr(12'd5, 32'hDEAD_BEEF, 4'b0011);
        chk("model_merge", model[5], 32'hAAAA_BEEF);
        fetch(32'd20, 32'hAAAA_BEEF, 1'b0);
        req_valid = 1'b0;
        idle(2);

`ifdef XF100_ITCM_ERR_CHK_EN
        fetch(32'h0000_0002, 32'h0000_0013, 1'b1);
        fetch(32'h0001_0000, 32'h0000_0013, 1'b1);
        fetch(32'h0000_0008, 32'h3333_3333, 1'b0);
`else
        fetch(32'h0001_0000, 32'h1111_1111, 1'b0);
        fetch(32'h0000_0006, 32'h2222_2222, 1'b0);
`endif
        req_valid = 1'b0;
        idle(3);

        // Reset with two pending responses.
        rsp_ready = 1'b0;
        fetch(32'h8, 32'h3333_3333, 1'b0);
        fetch(32'hC, 32'h4444_4444, 1'b0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("no_stale", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        fetch(32'h0, 32'h1111_1111, 1'b0);
        req_valid = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(1);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
